// File: rtl/shr_pkg.sv
// Shared definitions for shared-shifter controllers: state encoding and the
// rotating-priority pick used to choose the next requester.
package shr_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StShift = S_SHIFT,
    StHold  = S_HOLD
  } state_e;

  // Rotating priority encoder for up to 8 requesters.
  // Returns {any, id[2:0]}: the first set bit of vld scanning upward from ptr, wrapping at nreq.
  function automatic logic [3:0] rr_pick(input logic [7:0] vld, input logic [2:0] ptr,
                                         input int unsigned nreq);
    logic [3:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = (32'(ptr) + i) % nreq;
      if (i < nreq && !res[3] && vld[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shr_if.sv
// Requester/consumer bus of a shared shifter. The controller is the slave side.
interface shr_if #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2
);
  logic [NREQ-1:0]           req_vld;
  logic [NREQ-1:0]           req_rdy;
  logic [NREQ*DATAWIDTH-1:0] req_a;
  logic [NREQ*DATAWIDTH-1:0] req_sh;
  logic                      rsp_vld;
  logic                      rsp_rdy;
  logic [DATAWIDTH-1:0]      rsp_d;
  logic [IDW-1:0]            rsp_id;
  logic                      busy;

  modport master (
    output req_vld, req_a, req_sh, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_d, rsp_id, busy
  );

  modport slave (
    input  req_vld, req_a, req_sh, rsp_rdy,
    output req_rdy, rsp_vld, rsp_d, rsp_id, busy
  );
endinterface

// File: rtl/shr_rr_pick.sv
// Combinational round-robin pick: first valid requester at or above ptr, with wrap-around.
module shr_rr_pick
  import shr_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] vld_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            gnt_any_o
);

  logic [7:0] vld_ext;
  logic [2:0] ptr_ext;
  logic [3:0] pick;

  // Widen to the fixed 8-requester form the shared function works on.
  always_comb begin
    vld_ext   = 8'(vld_i);
    ptr_ext   = 3'(ptr_i);
    pick      = rr_pick(vld_ext, ptr_ext, NREQ);
    gnt_any_o = pick[3];
    gnt_id_o  = IDW'(pick[2:0]);
  end

endmodule

// File: rtl/shr_share_ctrl.sv
// Round-robin controller sharing one logical right shifter between NREQ requesters.
// Single entry: grant, latch operands, shift, hold the tagged result until accepted.
module shr_share_ctrl
  import shr_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2
) (
  input logic Clk,
  input logic Rst,
  shr_if.slave bus
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       gnt_id_q, gnt_id_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [IDW-1:0]       rsp_id_q, rsp_id_d;
  logic [NREQ-1:0]      req_rdy_q, req_rdy_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] sh_q, sh_d;
  logic [DATAWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic                 busy_q, busy_d;

  logic [IDW-1:0]       pick_id;
  logic                 pick_any;
  logic                 xfer;

  shr_rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .vld_i    (bus.req_vld),
    .ptr_i    (rr_ptr_q),
    .gnt_id_o (pick_id),
    .gnt_any_o(pick_any)
  );

  // Next-state logic; req_rdy is the registered grant decode, so only the flopped grant can transfer.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    req_rdy_d  = req_rdy_q;
    a_d        = a_q;
    sh_d       = sh_q;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = rsp_vld_q;
    xfer       = 1'b0;
    unique case (state_q)
      StIdle: begin
        xfer = |(bus.req_vld & req_rdy_q);
        if (xfer) begin
          a_d       = bus.req_a[gnt_id_q * DATAWIDTH +: DATAWIDTH];
          sh_d      = bus.req_sh[gnt_id_q * DATAWIDTH +: DATAWIDTH];
          id_d      = gnt_id_q;
          rr_ptr_d  = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
          req_rdy_d = '0;
          state_d   = StShift;
        end else begin
          // Re-arbitrate every idle cycle; a requester that dropped vld simply loses the grant.
          req_rdy_d = pick_any ? (NREQ'(1) << pick_id) : '0;
          gnt_id_d  = pick_id;
        end
      end
      StShift: begin
        // Full-width shift amount: anything >= DATAWIDTH yields zero.
        rsp_data_d = a_q >> sh_q;
        rsp_id_d   = id_q;
        rsp_vld_d  = 1'b1;
        state_d    = StHold;
      end
      StHold: begin
        if (bus.rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        req_rdy_d = '0;
        rsp_vld_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // FSM and output registers; reset discards any in-flight operation.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      id_q       <= '0;
      rsp_id_q   <= '0;
      req_rdy_q  <= '0;
      a_q        <= '0;
      sh_q       <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      req_rdy_q  <= req_rdy_d;
      a_q        <= a_d;
      sh_q       <= sh_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.req_rdy = req_rdy_q;
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_d   = rsp_data_q;
  assign bus.rsp_id  = rsp_id_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_shr_share_ctrl.sv
// Bench for shr_share_ctrl: directed scenarios plus randomized traffic against a
// round-robin / shift reference model.
module tb_shr_share_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned NR = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  shr_if #(.DATAWIDTH(DW), .NREQ(NR), .IDW(2)) bus ();

  shr_share_ctrl #(.DATAWIDTH(DW), .NREQ(NR), .IDW(2)) u_dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int          errors = 0;
  int          checks = 0;
  int          mdl_ptr = 0;
  logic [15:0] a_m  [NR];
  logic [15:0] sh_m [NR];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first pending requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [3:0] vld, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (vld[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Reference: logical right shift as integer division, zero once the amount reaches the width.
  function automatic logic [15:0] model_shift(input logic [15:0] a, input logic [15:0] sh);
    int unsigned q;
    if (sh >= 16) return 16'h0;
    q = 32'(a) / (32'd1 << sh);
    return q[15:0];
  endfunction

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] sh);
    a_m[id]  = a;
    sh_m[id] = sh;
    bus.req_a[id*DW +: DW]  = a;
    bus.req_sh[id*DW +: DW] = sh;
    bus.req_vld[id] = 1'b1;
  endtask

  // One full transaction for requester id, stalling the consumer for hold cycles.
  task automatic serve_one(input int id, input int hold);
    int          n;
    logic [15:0] exp_d;
    exp_d = model_shift(a_m[id], sh_m[id]);
    n = 0;
    while (bus.req_rdy == '0 && n < 8) begin
      tick();
      n++;
    end
    check("grant", 32'(bus.req_rdy), 32'(1) << id);
    tick();  // transfer edge
    bus.req_vld[id] = 1'b0;
    check("shift_busy", 32'(bus.busy), 32'd1);
    check("shift_rdy", 32'(bus.req_rdy), 32'd0);
    check("shift_vld", 32'(bus.rsp_vld), 32'd0);
    tick();
    check("rsp_vld", 32'(bus.rsp_vld), 32'd1);
    check("rsp_d", 32'(bus.rsp_d), 32'(exp_d));
    check("rsp_id", 32'(bus.rsp_id), 32'(id));
    repeat (hold) begin
      tick();
      check("hold_vld", 32'(bus.rsp_vld), 32'd1);
      check("hold_d", 32'(bus.rsp_d), 32'(exp_d));
      check("hold_id", 32'(bus.rsp_id), 32'(id));
      check("hold_rdy", 32'(bus.req_rdy), 32'd0);
    end
    bus.rsp_rdy = 1'b1;
    tick();
    bus.rsp_rdy = 1'b0;
    check("done_vld", 32'(bus.rsp_vld), 32'd0);
    check("done_busy", 32'(bus.busy), 32'd0);
    mdl_ptr = (id + 1) % 4;
  endtask

  initial begin
    int exp_id;
    int n;
    bus.req_vld = '0;
    bus.req_a   = '0;
    bus.req_sh  = '0;
    bus.rsp_rdy = 1'b0;

    // Reset held for three cycles, then idle with no requests.
    #1 Rst = 1'b0;
    repeat (3) tick();
    check("rst_vld", 32'(bus.rsp_vld), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    Rst = 1'b1;
    repeat (3) tick();
    check("idle_rdy", 32'(bus.req_rdy), 32'd0);
    check("idle_vld", 32'(bus.rsp_vld), 32'd0);
    check("idle_d", 32'(bus.rsp_d), 32'd0);
    check("idle_id", 32'(bus.rsp_id), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Single request: F0F0 >> 4.
    set_req(0, 16'hF0F0, 16'd4);
    check("single_ref", 32'(model_shift(16'hF0F0, 16'd4)), 32'h0F0F);
    serve_one(0, 0);

    // Pointer wrap: serve 3, then 0 and 3 together must pick 0.
    set_req(3, 16'h8001, 16'd15);
    serve_one(model_pick(bus.req_vld, mdl_ptr), 0);
    set_req(0, 16'h1234, 16'd0);
    set_req(3, 16'hFFFF, 16'd8);
    exp_id = model_pick(bus.req_vld, mdl_ptr);
    serve_one(exp_id, 0);
    serve_one(model_pick(bus.req_vld, mdl_ptr), 0);

    // All four at once, including one oversized shift; consumer stalls 5 cycles on one.
    set_req(0, 16'($urandom), 16'd1);
    set_req(1, 16'($urandom), 16'd2);
    set_req(2, 16'($urandom), 16'd3);
    set_req(3, 16'($urandom), 16'd17);
    for (int k = 0; k < 4; k++) begin
      exp_id = model_pick(bus.req_vld, mdl_ptr);
      serve_one(exp_id, (k == 2) ? 5 : 0);
    end

    // Randomized traffic with immediate re-requests.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req_vld[i] && $urandom_range(0, 1) == 1) begin
          set_req(i, 16'($urandom), 16'($urandom_range(0, 20)));
        end
      end
      if (bus.req_vld == '0) set_req(int'($urandom_range(0, 3)), 16'($urandom), 16'd5);
      exp_id = model_pick(bus.req_vld, mdl_ptr);
      serve_one(exp_id, int'($urandom_range(0, 3)));
    end
    n = 0;
    while (bus.req_vld != '0 && n < 4) begin
      serve_one(model_pick(bus.req_vld, mdl_ptr), 0);
      n++;
    end

    // Reset pulsed during HOLD: response vanishes at once and never comes back.
    set_req(1, 16'hABCD, 16'd3);
    n = 0;
    while (bus.req_rdy == '0 && n < 8) begin
      tick();
      n++;
    end
    tick();
    bus.req_vld[1] = 1'b0;
    tick();
    check("pre_rst_vld", 32'(bus.rsp_vld), 32'd1);
    #2 Rst = 1'b0;
    #1;
    check("async_vld", 32'(bus.rsp_vld), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_d", 32'(bus.rsp_d), 32'd0);
    check("async_id", 32'(bus.rsp_id), 32'd0);
    tick();
    Rst = 1'b1;
    mdl_ptr = 0;
    repeat (4) begin
      tick();
      check("post_rst_vld", 32'(bus.rsp_vld), 32'd0);
    end
    // Stale pointer would favour 3; a cleared pointer picks 1.
    set_req(1, 16'($urandom), 16'($urandom_range(0, 16)));
    set_req(3, 16'($urandom), 16'($urandom_range(0, 16)));
    serve_one(model_pick(bus.req_vld, mdl_ptr), 1);
    serve_one(model_pick(bus.req_vld, mdl_ptr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
